// File: rtl/add_sub_pkg.sv
// Shared constants for the 16-bit adder/subtractor datapath.
package add_sub_pkg;
    localparam int   ADD_SUB_WIDTH = 16;
    localparam logic OP_ADD        = 1'b0;
    localparam logic OP_SUB        = 1'b1;
endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder; the ripple-carry chain is built from WIDTH of these.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/add_sub_16bit.sv
// Registered two's-complement adder/subtractor: A+B when iSel=0, A-B when iSel=1,
// with carry-out and signed-overflow flags captured alongside the result.
import add_sub_pkg::*;

module add_sub_16bit #(
    parameter int WIDTH = ADD_SUB_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iSel,
    output logic [WIDTH-1:0] oS,
    output logic             oC,
    output logic             oV
);
    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    // Subtraction is A + ~B + 1: invert B and feed the select in as carry-in.
    assign sub      = (iSel == OP_SUB);
    assign bx       = iB ^ {WIDTH{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder_1bit u_fa (
            .a  (iA[i]),
            .b  (bx[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign s_d = sum;
    assign c_d = carry[WIDTH];
    assign v_d = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign oS = s_q;
    assign oC = c_q;
    assign oV = v_q;
endmodule

// File: tb/tb_add_sub_16bit.sv
// Bench for add_sub_16bit: directed literal cases plus randomized operations
// checked every cycle against an integer-arithmetic reference model.
module tb_add_sub_16bit;
    logic        iClk;
    logic        iRst_n;
    logic [15:0] iA;
    logic [15:0] iB;
    logic        iSel;
    logic [15:0] oS;
    logic        oC;
    logic        oV;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic [17:0] exp_q[$];

    add_sub_16bit dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iA     (iA),
        .iB     (iB),
        .iSel   (iSel),
        .oS     (oS),
        .oC     (oC),
        .oV     (oV)
    );

    // clock / reset
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Reference model: {v, c, s} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sel);
        int          ua, ub, sa, sb, sr;
        logic [15:0] s;
        logic        c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sel) begin
            s  = 16'((ua - ub) & 32'hFFFF);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            s  = 16'((ua + ub) & 32'hFFFF);
            c  = ((ua + ub) >= 65536);
            sr = sa + sb;
        end
        v = (sr > 32767) || (sr < -32768);
        return {v, c, s};
    endfunction

    task automatic compare(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got V=%b C=%b S=%h, expected V=%b C=%b S=%h",
                     name, act[17], act[16], act[15:0], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // driver: present operands at the falling edge
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sel);
        @(negedge iClk);
        iA   = a;
        iB   = b;
        iSel = sel;
    endtask

    // directed case with hand-computed expectations
    task automatic check_lit(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic sel, input logic [15:0] es, input logic ec, input logic ev);
        drive(a, b, sel);
        @(posedge iClk);
        #1;
        compare(name, {oV, oC, oS}, {ev, ec, es});
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    // scoreboard: every capturing edge is checked against the model
    initial begin
        logic [17:0] exp;
        forever begin
            @(posedge iClk);
            if (chk_en && iRst_n === 1'b1) begin
                exp_q.push_back(model(iA, iB, iSel));
                #1;
                exp = exp_q.pop_front();
                compare("model", {oV, oC, oS}, exp);
            end
        end
    end

    initial begin
        iRst_n = 1'b0;
        iA     = 16'h1234;
        iB     = 16'h0F0F;
        iSel   = 1'b0;

        // outputs held at zero while reset is low, even across edges
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            compare("reset_hold", {oV, oC, oS}, 18'h0);
        end
        #2 iRst_n = 1'b1;
        chk_en = 1;

        check_lit("add_5_3",      16'd5,   16'd3,   1'b0, 16'd8,    1'b0, 1'b0);
        check_lit("add_129_372",  16'd129, 16'd372, 1'b0, 16'd501,  1'b0, 1'b0);
        check_lit("add_987_347",  16'd987, 16'd347, 1'b0, 16'd1334, 1'b0, 1'b0);
        check_lit("sub_109_25",   16'd109, 16'd25,  1'b1, 16'd84,   1'b1, 1'b0);
        check_lit("sub_898_421",  16'd898, 16'd421, 1'b1, 16'd477,  1'b1, 1'b0);
        check_lit("sub_320_347",  16'd320, 16'd347, 1'b1, 16'hFFE5, 1'b0, 1'b0);
        check_lit("add_320_347",  16'd320, 16'd347, 1'b0, 16'd667,  1'b0, 1'b0);
        check_lit("add_wrap",     16'hFFFF, 16'd1,  1'b0, 16'h0000, 1'b1, 1'b0);
        check_lit("add_ovf",      16'h7FFF, 16'd1,  1'b0, 16'h8000, 1'b0, 1'b1);
        check_lit("sub_ovf",      16'h8000, 16'd1,  1'b1, 16'h7FFF, 1'b1, 1'b1);
        check_lit("sub_0_1",      16'd0,    16'd1,  1'b1, 16'hFFFF, 1'b0, 1'b0);

        // mid-stream reset between edges clears outputs before the next edge
        check_lit("pre_reset",    16'd1000, 16'd234, 1'b0, 16'd1234, 1'b0, 1'b0);
        @(negedge iClk);
        iA   = 16'h7FFF;
        iB   = 16'h0002;
        iSel = 1'b0;
        #2 iRst_n = 1'b0;
        #1 compare("async_reset", {oV, oC, oS}, 18'h0);
        @(negedge iClk);
        compare("reset_discard", {oV, oC, oS}, 18'h0);
        #2 iRst_n = 1'b1;
        @(posedge iClk);
        #1 compare("first_capture", {oV, oC, oS}, {1'b1, 1'b0, 16'h8001});

        // randomized back-to-back operations, sel toggling freely
        for (int i = 0; i < 400; i++) begin
            drive(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        @(posedge iClk);
        #2 chk_en = 0;
        @(negedge iClk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/add_sub_16bit.md
Name: add_sub_16bit

Overview:
- 16-bit two's-complement adder/subtractor, the arithmetic core of the basic CPU datapath (ALU add/sub path).
- Computes A+B or A−B, selected by one control bit; result, carry-out and signed-overflow flag are registered.
- Internally a ripple-carry chain of 1-bit full adders, with B conditionally inverted and carry-in equal to the select bit.

Parameters:
- WIDTH, 16, operand/result width in bits. Only 16 is verified.

Ports:
- iClk  input  1  clock, rising-edge active.
- iRst_n  input  1  asynchronous active-low reset.
- iA  input  16  operand A (unsigned or two's complement).
- iB  input  16  operand B.
- iSel  input  1  operation select: 0 = A+B, 1 = A−B.
- oS  output  16  registered result, modulo 2^16.
- oC  output  1  registered carry-out of the MSB stage.
- oV  output  1  registered signed-overflow flag.

Behaviour:
- Reset: iRst_n low clears oS = 16'h0000, oC = 0 and oV = 0 immediately, without waiting for a clock edge. The reset is held while iRst_n is low.
- Datapath (combinational, evaluated every cycle):
  - Bx = iB XOR {16{iSel}}.
  - {c16, sum} = iA + Bx + iSel, built as a 16-stage ripple of full adders with c0 = iSel.
- Register update: on every rising iClk edge with iRst_n high:
  - oS <= sum.
  - oC <= c16.
  - oV <= c16 XOR c15, i.e. the carries into and out of the MSB differ.
- Latency: exactly 1 cycle from operands/select to outputs. There is no enable and no handshake; a new operation is accepted every cycle.
- Add (iSel=0): oC = 1 iff the unsigned sum ≥ 65536; the result wraps modulo 2^16.
- Subtract (iSel=1): oC = 1 means no borrow (iA ≥ iB unsigned). oC = 0 means borrow, and oS is the two's-complement negative result.
- oV = 1 iff the signed result cannot be represented in 16 bits:
  - Add: operands have equal sign and the result sign differs.
  - Subtract: operands have opposite sign and the result sign differs from iA's sign.
- iSel toggling between cycles: each cycle's result depends only on that cycle's sampled inputs; no state is carried between operations.
- Reset deasserted asynchronously: the first capture occurs on the next rising edge.
- Reset asserted mid-stream: outputs clear immediately and any pending result is discarded.
- No X propagation from the sel path: iSel is a plain mux control on B and on carry-in.

Decomposition:
- Shared package add_sub_pkg:
  - constant ADD_SUB_WIDTH = 16.
  - constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
- Sub-module full_adder_1bit (a, b, ci -> s, co), instantiated WIDTH times in a generate loop.
- The top level holds the B-inversion XORs, the carry chain wiring, overflow detection and the output registers.

Test Plan:
- Reset then release → oS=0, oC=0, oV=0 while reset is held. Then A=5, B=3, Sel=0 → after 1 clk: oS=8, oC=0, oV=0.
- A=129, B=372, Sel=0 → oS=501, oC=0, oV=0. Then A=987, B=347, Sel=0 → oS=1334, oC=0, oV=0.
- Subtract without borrow, two operations in back-to-back cycles: first A=109, B=25, Sel=1 → oS=84, oC=1. Next cycle A=898, B=421, Sel=1 → oS=477, oC=1.
- A=320, B=347:
  - Sel=1 → oS=16'hFFE5 (−27), oC=0, oV=0.
  - Same operands with Sel=0 → oS=667, oC=0.
- Wrap and overflow:
  - A=16'hFFFF, B=1, Sel=0 → oS=0, oC=1, oV=0.
  - A=16'h7FFF, B=1, Sel=0 → oS=16'h8000, oV=1.
  - A=16'h8000, B=1, Sel=1 → oS=16'h7FFF, oC=1, oV=1.
- Assert iRst_n low between clock edges while outputs are nonzero → outputs go to 0 before the next edge. After release, the first edge captures the current inputs.
